// File: rtl/sar_searcher_pkg.sv
// Shared types and sizing helpers for the comparator-driven binary search engine.
package sar_searcher_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2,
    FAIL   = 2'd3
  } sar_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Probe counter must hold WIDTH+1, the worst-case probe count.
  function automatic int steps_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/sar_searcher_if.sv
// Handshake and result bundle between the searcher and its controller/comparator side.
interface sar_searcher_if
  import sar_searcher_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  localparam int STEPS_W = steps_width(WIDTH);

  logic               start;
  logic               gr;
  logic               eq;
  logic               le;
  logic [WIDTH-1:0]   guess;
  logic               busy;
  logic               done;
  logic               fail;
  logic [WIDTH-1:0]   found;
  logic [STEPS_W-1:0] steps;

  // master: controller plus comparator; slave: the searcher itself.
  modport master (
    output start, gr, eq, le,
    input  guess, busy, done, fail, found, steps
  );

  modport slave (
    input  start, gr, eq, le,
    output guess, busy, done, fail, found, steps
  );

endinterface

// File: rtl/sar_midpoint.sv
// Combinational midpoint of a [lo, hi] interval; the carry bit keeps the sum exact.
module sar_midpoint
  import sar_searcher_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] mid
);

  logic [WIDTH:0] sum_s;

  assign sum_s = {1'b0, lo} + {1'b0, hi};
  assign mid   = sum_s[WIDTH:1];

endmodule

// File: rtl/sar_searcher.sv
// Sequential binary search: presents a trial value to a comparator and narrows
// [lo, hi] on the gr/le flags until eq, reporting the hit and probe count.
module sar_searcher
  import sar_searcher_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           reset,
  sar_searcher_if.slave bus
);

  localparam int                 STEPS_W     = steps_width(WIDTH);
  localparam logic [WIDTH-1:0]   ALL_ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   FIRST_GUESS = ALL_ONES >> 1;
  localparam logic [WIDTH-1:0]   ONE_W       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STEPS_W-1:0] ONE_STEP    = {{(STEPS_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]         FLAG_GR     = 3'b100;
  localparam logic [2:0]         FLAG_EQ     = 3'b010;
  localparam logic [2:0]         FLAG_LE     = 3'b001;

  sar_state_t         state_r, state_next_s;
  logic [WIDTH-1:0]   lo_r, lo_next_s, lo_cand_s;
  logic [WIDTH-1:0]   hi_r, hi_next_s, hi_cand_s;
  logic [WIDTH-1:0]   guess_r, guess_next_s, mid_s;
  logic [WIDTH-1:0]   found_r, found_next_s;
  logic [STEPS_W-1:0] steps_r, steps_next_s;
  logic               busy_r, busy_next_s;
  logic               done_r, done_next_s;
  logic               fail_r, fail_next_s;
  logic [2:0]         flags_s;

  assign flags_s = {bus.gr, bus.eq, bus.le};

  // Candidate interval bounds after this probe; only meaningful for gr/le.
  always_comb begin
    lo_cand_s = lo_r;
    hi_cand_s = hi_r;
    if (flags_s == FLAG_LE) begin
      lo_cand_s = guess_r + ONE_W;
    end else if (flags_s == FLAG_GR) begin
      hi_cand_s = guess_r - ONE_W;
    end else begin
      lo_cand_s = lo_r;
      hi_cand_s = hi_r;
    end
  end

  sar_midpoint #(.WIDTH(WIDTH)) u_midpoint (
    .lo  (lo_cand_s),
    .hi  (hi_cand_s),
    .mid (mid_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_next_s = state_r;
    lo_next_s    = lo_r;
    hi_next_s    = hi_r;
    guess_next_s = guess_r;
    found_next_s = found_r;
    steps_next_s = steps_r;
    case (state_r)
      IDLE, DONE, FAIL: begin
        if (bus.start) begin
          state_next_s = SEARCH;
          lo_next_s    = {WIDTH{1'b0}};
          hi_next_s    = ALL_ONES;
          guess_next_s = FIRST_GUESS;
          steps_next_s = {STEPS_W{1'b0}};
        end else begin
          state_next_s = state_r;
        end
      end
      SEARCH: begin
        steps_next_s = steps_r + ONE_STEP;
        case (flags_s)
          FLAG_EQ: begin
            found_next_s = guess_r;
            state_next_s = DONE;
          end
          FLAG_GR: begin
            // Guess already at the floor: the target lies outside the interval.
            if (guess_r == lo_r) begin
              state_next_s = FAIL;
            end else begin
              hi_next_s    = hi_cand_s;
              guess_next_s = mid_s;
            end
          end
          FLAG_LE: begin
            if (guess_r == hi_r) begin
              state_next_s = FAIL;
            end else begin
              lo_next_s    = lo_cand_s;
              guess_next_s = mid_s;
            end
          end
          default: state_next_s = FAIL;
        endcase
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Status outputs are registered views of the state being entered.
  always_comb begin
    busy_next_s = (state_next_s == SEARCH);
    done_next_s = (state_r == SEARCH) && (state_next_s == DONE);
    fail_next_s = (state_r == SEARCH) && (state_next_s == FAIL);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      lo_r    <= {WIDTH{1'b0}};
      hi_r    <= ALL_ONES;
      guess_r <= {WIDTH{1'b0}};
      found_r <= {WIDTH{1'b0}};
      steps_r <= {STEPS_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fail_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      lo_r    <= lo_next_s;
      hi_r    <= hi_next_s;
      guess_r <= guess_next_s;
      found_r <= found_next_s;
      steps_r <= steps_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
      fail_r  <= fail_next_s;
    end
  end

  assign bus.guess = guess_r;
  assign bus.found = found_r;
  assign bus.steps = steps_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.fail  = fail_r;

endmodule

// File: tb/tb_sar_searcher.sv
// Self-checking bench: searcher paired with a behavioural comparator, table-driven
// searches plus hand-written fail/reset/restart sequences, results via scoreboard.
module tb_sar_searcher;

  localparam int W = 8;

  typedef struct {
    int target;
    int nsteps;
    int guesses [9];
  } vec_t;

  typedef struct {
    int found;
    int steps;
    bit is_fail;
  } exp_t;

  logic clk;
  logic reset;
  int   target;
  bit   force_en;
  logic [2:0] force_flags;

  int   n_total;
  int   n_pass;
  int   last_found;
  exp_t exp_q [$];
  vec_t vecs [7];

  sar_searcher_if #(.WIDTH(W)) bus ();

  sar_searcher #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator: a = guess, b = target, with an override for fault injection.
  always_comb begin
    if (force_en) begin
      {bus.gr, bus.eq, bus.le} = force_flags;
    end else begin
      bus.gr = (int'(bus.guess) > target);
      bus.eq = (int'(bus.guess) == target);
      bus.le = (int'(bus.guess) < target);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done/fail pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && (bus.done || bus.fail)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_pulse", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_fail_flag", int'(bus.fail), int'(e.is_fail));
        check("sb_done_flag", int'(bus.done), int'(!e.is_fail));
        check("sb_found", int'(bus.found), e.found);
        check("sb_steps", int'(bus.steps), e.steps);
        check("sb_busy_low", int'(bus.busy), 0);
      end
    end
  end

  task automatic push_exp(input int found, input int steps, input bit is_fail);
    exp_t e;
    e.found   = found;
    e.steps   = steps;
    e.is_fail = is_fail;
    exp_q.push_back(e);
  endtask

  // Pulse start, then walk the search until done/fail; returns probes seen while busy.
  task automatic run_search(input vec_t v, input bit chk_guess, output int probes);
    bit finished;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    probes   = 0;
    finished = 1'b0;
    for (int c = 0; c < 20 && !finished; c++) begin
      if (bus.done || bus.fail) begin
        finished = 1'b1;
      end else begin
        if (chk_guess && probes < 9) begin
          check($sformatf("guess_t%0d_p%0d", v.target, probes), int'(bus.guess), v.guesses[probes]);
        end
        probes++;
        @(negedge clk);
      end
    end
    check("search_terminates", int'(finished), 1);
    @(negedge clk);
    check("pulse_one_cycle", int'(bus.done || bus.fail), 0);
  endtask

  initial begin
    int   probes;
    vec_t v;

    n_total     = 0;
    n_pass      = 0;
    last_found  = 0;
    force_en    = 1'b0;
    force_flags = 3'b000;
    target      = 0;
    bus.start   = 1'b0;

    vecs[0].target = 100; vecs[0].nsteps = 8; vecs[0].guesses = '{127, 63, 95, 111, 103, 99, 101, 100, 0};
    vecs[1].target = 255; vecs[1].nsteps = 9; vecs[1].guesses = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    vecs[2].target = 0;   vecs[2].nsteps = 8; vecs[2].guesses = '{127, 63, 31, 15, 7, 3, 1, 0, 0};
    vecs[3].target = 127; vecs[3].nsteps = 1; vecs[3].guesses = '{127, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].target = 63;  vecs[4].nsteps = 2; vecs[4].guesses = '{127, 63, 0, 0, 0, 0, 0, 0, 0};
    vecs[5].target = 128; vecs[5].nsteps = 8; vecs[5].guesses = '{127, 191, 159, 143, 135, 131, 129, 128, 0};
    vecs[6].target = 1;   vecs[6].nsteps = 7; vecs[6].guesses = '{127, 63, 31, 15, 7, 3, 1, 0, 0};

    reset = 1'b1;
    #1;
    check("rst_guess", int'(bus.guess), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_fail", int'(bus.fail), 0);
    check("rst_found", int'(bus.found), 0);
    check("rst_steps", int'(bus.steps), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      target = vecs[i].target;
      push_exp(vecs[i].target, vecs[i].nsteps, 1'b0);
      run_search(vecs[i], 1'b1, probes);
      check($sformatf("probes_t%0d", vecs[i].target), probes, vecs[i].nsteps);
      last_found = vecs[i].target;
    end

    // Illegal flag combination on the very first probe.
    force_en    = 1'b1;
    force_flags = 3'b101;
    push_exp(last_found, 1, 1'b1);
    run_search(vecs[0], 1'b0, probes);
    check("probes_multi_hot", probes, 1);

    // Comparator insists guess > target all the way down to zero.
    force_flags = 3'b100;
    push_exp(last_found, 8, 1'b1);
    run_search(vecs[2], 1'b1, probes);
    check("probes_gr_at_zero", probes, 8);
    force_en = 1'b0;

    // Reset during the fourth probe aborts without any result pulse.
    target = 200;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", int'(bus.busy), 1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("abort_guess", int'(bus.guess), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_found", int'(bus.found), 0);
    check("abort_steps", int'(bus.steps), 0);
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_pulse", int'(bus.done || bus.fail), 0);
    end
    target = 127;
    push_exp(127, 1, 1'b0);
    run_search(vecs[3], 1'b1, probes);
    check("probes_after_abort", probes, 1);

    // start held high: ignored during SEARCH, restarts straight out of DONE.
    target = 63;
    push_exp(63, 2, 1'b0);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk);
    check("hold_p0_guess", int'(bus.guess), 127);
    @(negedge clk);
    check("hold_p1_guess", int'(bus.guess), 63);
    check("hold_p1_busy", int'(bus.busy), 1);
    @(negedge clk);
    check("hold_done", int'(bus.done), 1);
    push_exp(63, 2, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_busy", int'(bus.busy), 1);
    check("restart_guess", int'(bus.guess), 127);
    check("restart_steps", int'(bus.steps), 0);
    check("restart_done_low", int'(bus.done), 0);
    @(negedge clk);
    check("restart_p1_guess", int'(bus.guess), 63);
    @(negedge clk);
    check("restart_done", int'(bus.done), 1);
    repeat (2) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
